time_set_controller: RTL and testbench
======================================

# time_set_controller

Button-driven time-entry front end for the 12-hour BCD digital clock. It debounces three raw push-buttons and walks the user through hour, minute, second and AM/PM fields. It then presents the edited value on the clock's preset bus and fires the `set` strobe, so the clock counters load the new time. It runs on the same 100 kHz system clock as the clock core and drives that core's `hr`, `min`, `sec`, `dayNight` and `set` inputs.

## Interface
- DEBOUNCE_CYCLES, 2000, consecutive stable synchronized samples before a button level is accepted (20 ms at 100 kHz); minimum 2
- SET_PULSE_CYCLES, 4, width of the `set` strobe in clk cycles; minimum 1
- clk  in  1  system clock, 100 kHz
- reset  in  1  asynchronous, active-high; clears all state immediately
- btn_mode  in  1  raw, asynchronous "next field / enter edit" button, active-high
- btn_inc  in  1  raw, asynchronous increment button, active-high
- btn_dec  in  1  raw, asynchronous decrement button, active-high
- cur_time  in  24  live clock value {hr_bcd, min_bcd, sec_bcd}
- cur_am  in  1  live AM flag from the clock
- hr  out  8  BCD hour preset
- min  out  8  BCD minute preset
- sec  out  8  BCD second preset
- dayNight  out  1  AM/PM preset, 1 = day (AM)
- set  out  1  load strobe to the clock core, active-high
- editing  out  1  high in every state except IDLE
- edit_field  out  4  one-hot field selector {AMPM, SEC, MIN, HR}, for display blinking; 0 outside edit states

## Operation
- Button path, per button:
  - 2-FF synchronizer.
  - Counter that resets whenever the synced sample differs from the debounced level.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - Rising edge of the debounced level produces a registered 1-cycle press event.
  - Release produces no event.
- FSM states: IDLE, HR, MIN, SEC, AMPM, LOAD, STROBE.
- IDLE, mode press: capture cur_time into the edit registers and cur_am into dayNight, then go to HR. inc/dec are ignored in IDLE.
- HR, inc: 01→02…→12→01. HR, dec: 12→11…→01→12.
- MIN and SEC: inc 00…59→00; dec 00→59.
- Arithmetic is BCD: low digit 9 carries to the high digit; high digit borrows on low digit 0.
- Out-of-range captured value (digit >9, hr 00 or >12, min/sec >59):
  - inc loads the minimum (01 or 00).
  - dec loads the maximum (12 or 59).
- AMPM: inc or dec toggles dayNight.
- Mode press advances HR→MIN→SEC→AMPM→LOAD.
- LOAD: one cycle with presets stable and set low, then go to STROBE.
- STROBE: set high for exactly SET_PULSE_CYCLES cycles, then go to IDLE with set low.
- Outputs hr/min/sec/dayNight are driven directly from the edit registers. They change only in HR/MIN/SEC/AMPM, and are stable from LOAD entry through the end of STROBE.
- Simultaneous events:
  - inc and dec in the same cycle: both dropped.
  - mode together with inc/dec: mode wins, inc/dec dropped.
- Events arriving in LOAD/STROBE are dropped, not queued.
- There is no abort path; the field sequence always completes through STROBE.

## Timing
- Reset values:
  - state IDLE, set 0, editing 0, edit_field 0.
  - hr 0x11, min 0x59, sec 0x59, dayNight 0.
  - Synchronizers, counters, debounced levels and events all 0.
- Press latency: a raw button rising and held stable changes the state or outputs on the DEBOUNCE_CYCLES+4th rising clk edge after the edge that first samples it high.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
- Strobe timing:
  - set rises exactly 1 cycle after the presets are final (the LOAD cycle).
  - set is high SET_PULSE_CYCLES cycles.
  - The IDLE return is on the edge set falls.
- Reset asserted mid-STROBE: set drops asynchronously and the presets return to their reset values.
- A held button produces exactly one event; the next event requires release then re-press, each stable for DEBOUNCE_CYCLES.

## Test plan
- Reset and strobe sequence (DEBOUNCE_CYCLES=4, SET_PULSE_CYCLES=4 for all sims):
  - Reset → presets 11:59:59, dayNight 0, set 0, editing 0.
  - Then mode ×5 with cur_time=0x103045, cur_am=1 → set high 4 cycles, presets 0x10/0x30/0x45, dayNight 1.
- Wrap checks: from HR=0x12 inc → 0x01, dec → 0x12; MIN 0x59 inc → 0x00, 0x00 dec → 0x59; SEC 0x09 inc → 0x10.
- Invalid capture: cur_time hr=0x00, min=0x7A; HR inc → 0x01; MIN dec → 0x59.
- Debounce:
  - 3-cycle btn_inc glitch → no change.
  - Press held 100 cycles → exactly one increment, applied at DEBOUNCE_CYCLES+4 edges.
- Simultaneous and late events:
  - inc+dec same cycle in MIN → value unchanged.
  - mode+inc same cycle in HR → state MIN, hr unchanged.
  - Presses during STROBE → ignored, state IDLE afterwards.
- Reset while set high → set 0 immediately, state IDLE, presets at reset values.

Source files
------------

// File: rtl/time_set_controller.sv
// Button-driven time-entry front end for the 12-hour BCD clock: debounces three buttons,
// walks the HR/MIN/SEC/AMPM fields and strobes the edited value into the clock core.
module time_set_controller #(
    parameter int unsigned DEBOUNCE_CYCLES  = 2000,
    parameter int unsigned SET_PULSE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    input  logic        cur_am,
    output logic [7:0]  hr,
    output logic [7:0]  min,
    output logic [7:0]  sec,
    output logic        dayNight,
    output logic        set,
    output logic        editing,
    output logic [3:0]  edit_field
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW = $clog2(SET_PULSE_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StHr, StMin, StSec, StAmpm, StLoad, StStrobe
    } state_e;

    logic [2:0] btn_raw;
    logic [2:0] press;

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic          s1_q, s2_q, lvl_q, lvl_dly_q, ev_q;
        logic [CW-1:0] cnt_q;

        // Level flips only after the synced sample has disagreed for a full count.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                lvl_q     <= 1'b0;
                lvl_dly_q <= 1'b0;
                ev_q      <= 1'b0;
                cnt_q     <= '0;
            end else begin
                s1_q <= btn_raw[g];
                s2_q <= s1_q;
                if (s2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    lvl_q <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                lvl_dly_q <= lvl_q;
                ev_q      <= lvl_q & ~lvl_dly_q;
            end
        end

        assign press[g] = ev_q;
    end

    function automatic logic [7:0] bcd_up(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_down(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic hr_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd1) && (v[3:0] <= 4'd9) && (v != 8'h00) &&
               !((v[7:4] == 4'd1) && (v[3:0] > 4'd2));
    endfunction

    function automatic logic ms_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] hr_step(input logic [7:0] v, input logic up);
        if (up) return (!hr_ok(v) || v == 8'h12) ? 8'h01 : bcd_up(v);
        else    return (!hr_ok(v) || v == 8'h01) ? 8'h12 : bcd_down(v);
    endfunction

    function automatic logic [7:0] ms_step(input logic [7:0] v, input logic up);
        if (up) return (!ms_ok(v) || v == 8'h59) ? 8'h00 : bcd_up(v);
        else    return (!ms_ok(v) || v == 8'h00) ? 8'h59 : bcd_down(v);
    endfunction

    state_e        state_q, state_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic [7:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic          dn_q, dn_d;
    logic          mode_ev, adj_ev, adj_up;

    // Mode beats inc/dec; inc and dec together cancel.
    assign mode_ev = press[0];
    assign adj_ev  = !press[0] && (press[1] ^ press[2]);
    assign adj_up  = press[1];

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        dn_d    = dn_q;
        unique case (state_q)
            StIdle: begin
                if (mode_ev) begin
                    hr_d    = cur_time[23:16];
                    min_d   = cur_time[15:8];
                    sec_d   = cur_time[7:0];
                    dn_d    = cur_am;
                    state_d = StHr;
                end
            end
            StHr: begin
                if (mode_ev)     state_d = StMin;
                else if (adj_ev) hr_d = hr_step(hr_q, adj_up);
            end
            StMin: begin
                if (mode_ev)     state_d = StSec;
                else if (adj_ev) min_d = ms_step(min_q, adj_up);
            end
            StSec: begin
                if (mode_ev)     state_d = StAmpm;
                else if (adj_ev) sec_d = ms_step(sec_q, adj_up);
            end
            StAmpm: begin
                if (mode_ev)     state_d = StLoad;
                else if (adj_ev) dn_d = ~dn_q;
            end
            StLoad: begin
                state_d = StStrobe;
                pulse_d = '0;
            end
            StStrobe: begin
                if (pulse_q == PW'(SET_PULSE_CYCLES - 1)) state_d = StIdle;
                else                                      pulse_d = pulse_q + PW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pulse_q <= '0;
            hr_q    <= 8'h11;
            min_q   <= 8'h59;
            sec_q   <= 8'h59;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            dn_q    <= dn_d;
        end
    end

    assign hr       = hr_q;
    assign min      = min_q;
    assign sec      = sec_q;
    assign dayNight = dn_q;
    assign set      = (state_q == StStrobe);
    assign editing  = (state_q != StIdle);

    always_comb begin
        edit_field = 4'b0000;
        case (state_q)
            StHr:    edit_field = 4'b0001;
            StMin:   edit_field = 4'b0010;
            StSec:   edit_field = 4'b0100;
            StAmpm:  edit_field = 4'b1000;
            default: edit_field = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: directed button presses queue expected
// output snapshots; a negedge monitor checks every observed output change against them.
module tb_time_set_controller;

    localparam int unsigned D   = 4;
    localparam int unsigned P   = 4;
    localparam int          LAT = D + 5;

    logic        clk, reset, btn_mode, btn_inc, btn_dec, cur_am;
    logic [23:0] cur_time;
    logic [7:0]  hr, min, sec;
    logic        dayNight, set, editing;
    logic [3:0]  edit_field;

    time_set_controller #(
        .DEBOUNCE_CYCLES (D),
        .SET_PULSE_CYCLES(P)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_time  (cur_time),
        .cur_am    (cur_am),
        .hr        (hr),
        .min       (min),
        .sec       (sec),
        .dayNight  (dayNight),
        .set       (set),
        .editing   (editing),
        .edit_field(edit_field)
    );

    typedef struct {
        string      tag;
        logic [7:0] h, m, s;
        logic       dn, ed;
        logic [3:0] fld;
        logic       st;
        int         cyc;
    } snap_t;

    snap_t       exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic        mon_en = 1'b0;
    logic [30:0] prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every change of the observable outputs consumes one expected snapshot.
    initial forever begin
        logic [30:0] cur, want;
        snap_t       e;
        @(negedge clk);
        if (mon_en) begin
            cur = {hr, min, sec, dayNight, editing, edit_field, set};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got %h/%h/%h dn=%b ed=%b fld=%b set=%b @%0d, required no change",
                             hr, min, sec, dayNight, editing, edit_field, set, cyc);
                end else begin
                    e    = exp_q.pop_front();
                    want = {e.h, e.m, e.s, e.dn, e.ed, e.fld, e.st};
                    if (cur !== want || (e.cyc >= 0 && e.cyc != cyc)) begin
                        n_fail++;
                        $display("FAIL %s: got %h/%h/%h dn=%b ed=%b fld=%b set=%b @%0d, required %h/%h/%h dn=%b ed=%b fld=%b set=%b @%0d",
                                 e.tag, hr, min, sec, dayNight, editing, edit_field, set, cyc,
                                 e.h, e.m, e.s, e.dn, e.ed, e.fld, e.st, e.cyc);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic dn, input logic ed,
                        input logic [3:0] fld, input logic st, input int c);
        snap_t e;
        e.tag = tag; e.h = h; e.m = m; e.s = s; e.dn = dn; e.ed = ed;
        e.fld = fld; e.st = st; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic raise(input logic m, input logic i, input logic d, output int c0);
        @(posedge clk);
        #1;
        btn_mode = btn_mode | m;
        btn_inc  = btn_inc | i;
        btn_dec  = btn_dec | d;
        c0 = cyc;
    endtask

    task automatic hold_release(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (16) @(posedge clk);
    endtask

    task automatic press_exp(input logic m, input logic i, input logic d, input int hold,
                             input string tag, input logic [7:0] h, input logic [7:0] mi,
                             input logic [7:0] s, input logic dn, input logic [3:0] fld);
        int c;
        raise(m, i, d, c);
        push(tag, h, mi, s, dn, 1'b1, fld, 1'b0, c + LAT);
        hold_release(hold);
    endtask

    task automatic press_none(input logic m, input logic i, input logic d, input int hold);
        int c;
        raise(m, i, d, c);
        hold_release(hold);
    endtask

    // LOAD cycle, then set for P cycles, then IDLE on the edge set falls.
    task automatic push_strobe(input string tag, input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, input logic dn, input int e);
        push({tag, "_load"}, h, m, s, dn, 1'b1, 4'b0000, 1'b0, e);
        push({tag, "_set"}, h, m, s, dn, 1'b1, 4'b0000, 1'b1, e + 1);
        push({tag, "_idle"}, h, m, s, dn, 1'b0, 4'b0000, 1'b0, e + 1 + P);
    endtask

    initial begin
        int c, c2, k;
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_time = 24'h103045; cur_am = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_hr", hr, 8'h11);
        check("rst_min", min, 8'h59);
        check("rst_sec", sec, 8'h59);
        check("rst_dn", 8'(dayNight), 8'h0);
        check("rst_set", 8'(set), 8'h0);
        check("rst_editing", 8'(editing), 8'h0);
        check("rst_field", 8'(edit_field), 8'h0);
        prev   = {hr, min, sec, dayNight, editing, edit_field, set};
        mon_en = 1'b1;

        // Plain walk through all fields and the strobe.
        press_exp(1, 0, 0, 10, "capA", 8'h10, 8'h30, 8'h45, 1, 4'b0001);
        press_exp(1, 0, 0, 10, "a_min", 8'h10, 8'h30, 8'h45, 1, 4'b0010);
        press_exp(1, 0, 0, 10, "a_sec", 8'h10, 8'h30, 8'h45, 1, 4'b0100);
        press_exp(1, 0, 0, 10, "a_ampm", 8'h10, 8'h30, 8'h45, 1, 4'b1000);
        raise(1, 0, 0, c);
        push_strobe("strA", 8'h10, 8'h30, 8'h45, 1, c + LAT);
        hold_release(10);

        // Wraps and carries.
        cur_time = 24'h125909; cur_am = 1'b0;
        press_exp(1, 0, 0, 10, "capB", 8'h12, 8'h59, 8'h09, 0, 4'b0001);
        press_exp(0, 1, 0, 10, "hr_inc_wrap", 8'h01, 8'h59, 8'h09, 0, 4'b0001);
        press_exp(0, 0, 1, 10, "hr_dec_wrap", 8'h12, 8'h59, 8'h09, 0, 4'b0001);
        press_exp(1, 0, 0, 10, "b_min", 8'h12, 8'h59, 8'h09, 0, 4'b0010);
        press_exp(0, 1, 0, 10, "min_inc_wrap", 8'h12, 8'h00, 8'h09, 0, 4'b0010);
        press_exp(0, 0, 1, 10, "min_dec_wrap", 8'h12, 8'h59, 8'h09, 0, 4'b0010);
        press_exp(1, 0, 0, 10, "b_sec", 8'h12, 8'h59, 8'h09, 0, 4'b0100);
        press_exp(0, 1, 0, 10, "sec_inc_carry", 8'h12, 8'h59, 8'h10, 0, 4'b0100);
        press_exp(1, 0, 0, 10, "b_ampm", 8'h12, 8'h59, 8'h10, 0, 4'b1000);
        press_exp(0, 1, 0, 10, "ampm_inc", 8'h12, 8'h59, 8'h10, 1, 4'b1000);
        press_exp(0, 0, 1, 10, "ampm_dec", 8'h12, 8'h59, 8'h10, 0, 4'b1000);
        raise(1, 0, 0, c);
        push_strobe("strB", 8'h12, 8'h59, 8'h10, 0, c + LAT);
        hold_release(10);

        // Invalid capture, debounce, simultaneous events, presses during strobe.
        cur_time = 24'h007A00; cur_am = 1'b0;
        press_exp(1, 0, 0, 10, "capC", 8'h00, 8'h7A, 8'h00, 0, 4'b0001);
        press_exp(0, 1, 0, 10, "hr_inc_invalid", 8'h01, 8'h7A, 8'h00, 0, 4'b0001);
        press_none(0, 1, 0, 3);
        press_exp(0, 1, 0, 100, "hr_inc_held", 8'h02, 8'h7A, 8'h00, 0, 4'b0001);
        press_exp(1, 1, 0, 10, "mode_wins", 8'h02, 8'h7A, 8'h00, 0, 4'b0010);
        press_exp(0, 0, 1, 10, "min_dec_invalid", 8'h02, 8'h59, 8'h00, 0, 4'b0010);
        press_none(0, 1, 1, 10);
        press_exp(1, 0, 0, 10, "c_sec", 8'h02, 8'h59, 8'h00, 0, 4'b0100);
        press_exp(1, 0, 0, 10, "c_ampm", 8'h02, 8'h59, 8'h00, 0, 4'b1000);
        raise(1, 0, 0, c);
        push_strobe("strC", 8'h02, 8'h59, 8'h00, 0, c + LAT);
        raise(0, 1, 0, c2);
        raise(0, 0, 1, c2);
        hold_release(10);
        check("idle_after_strobe", 8'(editing), 8'h0);
        check("hr_after_strobe", hr, 8'h02);

        // Reset while set is high.
        cur_time = 24'h010203; cur_am = 1'b1;
        press_exp(1, 0, 0, 10, "capD", 8'h01, 8'h02, 8'h03, 1, 4'b0001);
        press_exp(1, 0, 0, 10, "d_min", 8'h01, 8'h02, 8'h03, 1, 4'b0010);
        press_exp(1, 0, 0, 10, "d_sec", 8'h01, 8'h02, 8'h03, 1, 4'b0100);
        press_exp(1, 0, 0, 10, "d_ampm", 8'h01, 8'h02, 8'h03, 1, 4'b1000);
        raise(1, 0, 0, c);
        push("strD_load", 8'h01, 8'h02, 8'h03, 1, 1, 4'b0000, 0, c + LAT);
        push("strD_set", 8'h01, 8'h02, 8'h03, 1, 1, 4'b0000, 1, c + LAT + 1);
        k = 0;
        while (set !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("set_seen", 8'(set), 8'h1);
        #2;
        push("rst_mid_strobe", 8'h11, 8'h59, 8'h59, 0, 0, 4'b0000, 0, -1);
        reset = 1'b1;
        #1;
        check("rst_async_set", 8'(set), 8'h0);
        check("rst_async_editing", 8'(editing), 8'h0);
        check("rst_async_hr", hr, 8'h11);
        check("rst_async_min", min, 8'h59);
        check("rst_async_sec", sec, 8'h59);
        check("rst_async_dn", 8'(dayNight), 8'h0);
        btn_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        while (exp_q.size() != 0) begin
            snap_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got no output change, required change @%0d", e.tag, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
